acc_stream_driver: RTL and testbench

- Hardware front end for the gravity `accelerator` pipeline.
- Holds a buffer of pair records (m2, b1 x/y, b2 x/y, incoming acceleration x/y) loaded by the host.
- On start, streams one record per cycle into the accelerator and injects each record's incoming acceleration at the pipeline's accumulate stage.
- Captures each result at a fixed latency into a result RAM that the host reads back.

---
 rtl/acc_drv_pkg.sv | 26 ++
 rtl/acc_tag_delay.sv | 26 ++
 rtl/acc_stream_driver.sv | 225 ++++++++++++++++++++++
 tb/tb_acc_stream_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_drv_pkg.sv
// Shared types and defaults for the accelerator stream driver.
package acc_drv_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned LATENCY_DEF   = 19;
  localparam int unsigned IA_OFFSET_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One host-loaded pair record
  typedef struct packed {
    logic [WORD_W-1:0] m2;
    logic [WORD_W-1:0] x1;
    logic [WORD_W-1:0] y1;
    logic [WORD_W-1:0] x2;
    logic [WORD_W-1:0] y2;
    logic [WORD_W-1:0] ia_x;
    logic [WORD_W-1:0] ia_y;
  } rec_t;

endpackage

// File: rtl/acc_tag_delay.sv
// Resettable fixed-depth shift register; used for the result tag line and the ia delay line.
module acc_tag_delay #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [STAGES];

  // Shift one stage per cycle; reset flushes every stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(STAGES); i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < int'(STAGES); i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[STAGES-1];

endmodule

// File: rtl/acc_stream_driver.sv
// Front end for the gravity accelerator: streams host-loaded records, injects
// incoming acceleration at the accumulate stage, captures results into a RAM.
// Optional result checksum enabled by defining ACC_DRV_CHECKSUM_EN.
module acc_stream_driver
  import acc_drv_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = 8,
  parameter int unsigned LATENCY   = LATENCY_DEF,
  parameter int unsigned IA_OFFSET = IA_OFFSET_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_m2,
  input  logic [WORD_W-1:0] i_wr_x1,
  input  logic [WORD_W-1:0] i_wr_y1,
  input  logic [WORD_W-1:0] i_wr_x2,
  input  logic [WORD_W-1:0] i_wr_y2,
  input  logic [WORD_W-1:0] i_wr_ia_x,
  input  logic [WORD_W-1:0] i_wr_ia_y,
  input  logic [AW:0]       i_count,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [WORD_W-1:0] o_b1_x,
  output logic [WORD_W-1:0] o_b1_y,
  output logic [WORD_W-1:0] o_b2_x,
  output logic [WORD_W-1:0] o_b2_y,
  output logic [WORD_W-1:0] o_m_b2,
  output logic [WORD_W-1:0] o_a_b1_x,
  output logic [WORD_W-1:0] o_a_b1_y,
  input  logic [WORD_W-1:0] i_acc_x,
  input  logic [WORD_W-1:0] i_acc_y,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [WORD_W-1:0] o_rd_ax,
  output logic [WORD_W-1:0] o_rd_ay,
  output logic [WORD_W-1:0] o_checksum
);

  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TW  = AW + 1;
  localparam int unsigned IAW = 2 * WORD_W;

  rec_t              r_rec_mem [DEPTH];
  logic [WORD_W-1:0] r_res_x   [DEPTH];
  logic [WORD_W-1:0] r_res_y   [DEPTH];

  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_k;
  logic [CW-1:0]     r_n;
  logic [CW-1:0]     w_n_start;
  logic [AW-1:0]     w_rd_idx;
  logic              w_start_ok;
  logic              w_issue;
  logic              w_tag_last;
  logic              w_tag_vld;
  logic [AW-1:0]     w_tag_idx;
  logic              w_res_we;
  logic              w_rec_we;
  rec_t              w_rec;
  rec_t              w_wr_rec;
  logic [TW-1:0]     r_tag_in, w_tag_out;
  logic [IAW-1:0]    r_ia, w_ia_out;

  logic              r_busy, r_done;
  logic [WORD_W-1:0] r_b1_x, r_b1_y, r_b2_x, r_b2_y, r_m_b2;
  logic [WORD_W-1:0] r_rd_ax, r_rd_ay;

  assign w_n_start = (i_count > CW'(DEPTH)) ? CW'(DEPTH) : i_count;
  assign w_rec     = r_rec_mem[w_rd_idx];
  assign w_tag_vld = w_tag_out[TW-1];
  assign w_tag_idx = w_tag_out[AW-1:0];
  assign w_tag_last = w_tag_vld && (CW'(w_tag_idx) == (r_n - CW'(1)));
  assign w_res_we  = w_tag_vld && !i_rst;
  assign w_rec_we  = i_wr_en && (r_state == ST_IDLE) && !i_rst;
  assign w_wr_rec  = '{m2: i_wr_m2, x1: i_wr_x1, y1: i_wr_y1, x2: i_wr_x2,
                       y2: i_wr_y2, ia_x: i_wr_ia_x, ia_y: i_wr_ia_y};

  // Next-state and issue decode; record 0 is issued on the start edge itself
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_ok  = 1'b0;
    w_rd_idx    = r_k;
    case (r_state)
      ST_IDLE: begin
        w_rd_idx = '0;
        if (i_start) begin
          w_start_ok = 1'b1;
          if (w_n_start != '0) begin
            w_issue     = 1'b1;
            w_state_nxt = (w_n_start == CW'(1)) ? ST_DRAIN : ST_ISSUE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        w_issue = 1'b1;
        if (CW'(r_k) == (r_n - CW'(1))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_tag_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, count/index registers and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_n     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_start_ok) begin
        r_n <= w_n_start;
        r_k <= AW'(1);
      end else if (w_issue) begin
        r_k <= r_k + AW'(1);
      end
    end
  end

  // Issue stage: present the record, launch its ia and tag; zeros in idle slots
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_issue) begin
      r_b1_x   <= '0;
      r_b1_y   <= '0;
      r_b2_x   <= '0;
      r_b2_y   <= '0;
      r_m_b2   <= '0;
      r_ia     <= '0;
      r_tag_in <= '0;
    end else begin
      r_b1_x   <= w_rec.x1;
      r_b1_y   <= w_rec.y1;
      r_b2_x   <= w_rec.x2;
      r_b2_y   <= w_rec.y2;
      r_m_b2   <= w_rec.m2;
      r_ia     <= {w_rec.ia_x, w_rec.ia_y};
      r_tag_in <= {1'b1, w_rd_idx};
    end
  end

  acc_tag_delay #(.STAGES(LATENCY), .WIDTH(TW)) u_tag_line (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (r_tag_in),
    .o_q   (w_tag_out)
  );

  acc_tag_delay #(.STAGES(IA_OFFSET), .WIDTH(IAW)) u_ia_line (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (r_ia),
    .o_q   (w_ia_out)
  );

  // Host record writes, accepted only while idle
  always_ff @(posedge i_clk) begin
    if (w_rec_we) r_rec_mem[i_wr_addr] <= w_wr_rec;
  end

  // Capture accelerator output when the matching tag emerges
  always_ff @(posedge i_clk) begin
    if (w_res_we) begin
      r_res_x[w_tag_idx] <= i_acc_x;
      r_res_y[w_tag_idx] <= i_acc_y;
    end
  end

  // Registered host readback; a same-cycle write returns the old entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ax <= '0;
      r_rd_ay <= '0;
    end else begin
      r_rd_ax <= r_res_x[i_rd_addr];
      r_rd_ay <= r_res_y[i_rd_addr];
    end
  end

`ifdef ACC_DRV_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  // XOR of every captured result word since the last accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_ok) begin
      r_checksum <= '0;
    end else if (w_res_we) begin
      r_checksum <= r_checksum ^ i_acc_x ^ i_acc_y;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_b1_x   = r_b1_x;
  assign o_b1_y   = r_b1_y;
  assign o_b2_x   = r_b2_x;
  assign o_b2_y   = r_b2_y;
  assign o_m_b2   = r_m_b2;
  assign o_a_b1_x = w_ia_out[IAW-1 -: WORD_W];
  assign o_a_b1_y = w_ia_out[WORD_W-1:0];
  assign o_rd_ax  = r_rd_ax;
  assign o_rd_ay  = r_rd_ay;

endmodule

// File: tb/tb_acc_stream_driver.sv
// Directed bench for acc_stream_driver with a 3-cycle echo stub accelerator.
module tb_acc_stream_driver;

  localparam int LAT = 19;
  localparam int IA  = 16;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_wr_en;
  logic [7:0]  i_wr_addr;
  logic [31:0] i_wr_m2, i_wr_x1, i_wr_y1, i_wr_x2, i_wr_y2, i_wr_ia_x, i_wr_ia_y;
  logic [8:0]  i_count;
  logic        i_start;
  logic        o_busy, o_done;
  logic [31:0] o_b1_x, o_b1_y, o_b2_x, o_b2_y, o_m_b2, o_a_b1_x, o_a_b1_y;
  logic [31:0] i_acc_x, i_acc_y;
  logic [7:0]  i_rd_addr;
  logic [31:0] o_rd_ax, o_rd_ay, o_checksum;

  logic [31:0] m_rec   [256][7];
  logic [31:0] m_res_x [256];
  logic [31:0] m_res_y [256];
  logic [63:0] s0, s1, s2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  acc_stream_driver dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_m2(i_wr_m2), .i_wr_x1(i_wr_x1), .i_wr_y1(i_wr_y1), .i_wr_x2(i_wr_x2),
    .i_wr_y2(i_wr_y2), .i_wr_ia_x(i_wr_ia_x), .i_wr_ia_y(i_wr_ia_y),
    .i_count(i_count), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_b1_x(o_b1_x), .o_b1_y(o_b1_y), .o_b2_x(o_b2_x), .o_b2_y(o_b2_y),
    .o_m_b2(o_m_b2), .o_a_b1_x(o_a_b1_x), .o_a_b1_y(o_a_b1_y),
    .i_acc_x(i_acc_x), .i_acc_y(i_acc_y), .i_rd_addr(i_rd_addr),
    .o_rd_ax(o_rd_ax), .o_rd_ay(o_rd_ay), .o_checksum(o_checksum)
  );

  // Stub accelerator: echoes the injected acceleration three cycles later
  always @(posedge clk) begin
    s0 <= {o_a_b1_x, o_a_b1_y};
    s1 <= s0;
    s2 <= s1;
  end
  assign i_acc_x = s2[63:32];
  assign i_acc_y = s2[31:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int f, input int k);
    if (f == 0 && k == 0) return 32'h3F80_0000;
    if (f == 0 && k == 1) return 32'h4000_0000;
    if (f == 0 && k == 2) return 32'h4040_0000;
    return {4'(f + 1), 4'hA, 16'(k * 977 + f * 31), 8'(k)};
  endfunction

  task automatic set_wr(input int a, input logic [31:0] v [7]);
    i_wr_addr = 8'(a);
    i_wr_m2 = v[0]; i_wr_x1 = v[1]; i_wr_y1 = v[2]; i_wr_x2 = v[3];
    i_wr_y2 = v[4]; i_wr_ia_x = v[5]; i_wr_ia_y = v[6];
  endtask

  task automatic load_all();
    logic [31:0] v [7];
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      for (int f = 0; f < 7; f++) begin
        v[f] = pat(f, k);
        m_rec[k][f] = v[f];
      end
      set_wr(k, v);
      i_wr_en = 1'b1;
    end
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input int a);
    @(negedge clk);
    i_rd_addr = 8'(a);
    @(negedge clk);
    check($sformatf("rd_ax[%0d]", a), o_rd_ax, m_res_x[a]);
    check($sformatf("rd_ay[%0d]", a), o_rd_ay, m_res_y[a]);
  endtask

  // Start a run and check every output cycle by cycle against the record model
  task automatic run(input int cnt, input int inj_at, input int rst_at);
    int n, done_at, last_j, ks, ki;
    logic [31:0] cs, ex_x, ex_y;
    logic [31:0] er [5];
    logic [31:0] dv [7];
    n = (cnt > 256) ? 256 : cnt;
    done_at = (n == 0) ? 1 : 1 + n + LAT;
    last_j = (rst_at > 0) ? rst_at + 1 : done_at + 2;
    cs = '0;
    for (int k = 0; k < n; k++) cs = cs ^ m_rec[k][5] ^ m_rec[k][6];
    @(negedge clk);
    i_count = 9'(cnt);
    i_start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      if (j == 1) i_start = 1'b0;
      if (rst_at > 0 && j == rst_at + 1) begin
        check("mid_rst_data", o_b1_x | o_b1_y | o_b2_x | o_b2_y | o_m_b2 | o_a_b1_x | o_a_b1_y, 32'h0);
        check("mid_rst_ctl", {30'h0, o_busy, o_done}, 32'h0);
        i_rst = 1'b0;
      end else begin
        ks = j - 1;
        ki = j - 1 - IA;
        for (int f = 0; f < 5; f++) er[f] = (ks < n) ? m_rec[ks][f] : 32'h0;
        ex_x = (ki >= 0 && ki < n) ? m_rec[ki][5] : 32'h0;
        ex_y = (ki >= 0 && ki < n) ? m_rec[ki][6] : 32'h0;
        check($sformatf("m_b2@%0d", j), o_m_b2, er[0]);
        check($sformatf("b1_x@%0d", j), o_b1_x, er[1]);
        check($sformatf("b1_y@%0d", j), o_b1_y, er[2]);
        check($sformatf("b2_x@%0d", j), o_b2_x, er[3]);
        check($sformatf("b2_y@%0d", j), o_b2_y, er[4]);
        check($sformatf("a_b1_x@%0d", j), o_a_b1_x, ex_x);
        check($sformatf("a_b1_y@%0d", j), o_a_b1_y, ex_y);
        check($sformatf("done@%0d", j), {31'h0, o_done}, {31'h0, j == done_at});
        check($sformatf("busy@%0d", j), {31'h0, o_busy}, {31'h0, j <= done_at});
        if (j == done_at) begin
`ifdef ACC_DRV_CHECKSUM_EN
          check("checksum", o_checksum, cs);
`else
          check("checksum", o_checksum, 32'h0);
`endif
        end
        if (inj_at > 0 && j == inj_at) begin
          for (int f = 0; f < 7; f++) dv[f] = 32'hDEAD_0000 + 32'(f);
          set_wr(0, dv);
          i_wr_en = 1'b1;
          i_start = 1'b1;
          i_count = 9'd5;
        end
        if (inj_at > 0 && j == inj_at + 1) begin
          i_wr_en = 1'b0;
          i_start = 1'b0;
        end
        if (rst_at > 0 && j == rst_at) i_rst = 1'b1;
      end
    end
    if (rst_at == 0) begin
      for (int k = 0; k < n; k++) begin
        m_res_x[k] = m_rec[k][5];
        m_res_y[k] = m_rec[k][6];
      end
    end
  endtask

  initial begin
    logic [31:0] rv [7];
    i_rst = 1'b1; i_wr_en = 1'b0; i_start = 1'b0; i_count = '0;
    i_rd_addr = '0; i_wr_addr = '0;
    i_wr_m2 = '0; i_wr_x1 = '0; i_wr_y1 = '0; i_wr_x2 = '0;
    i_wr_y2 = '0; i_wr_ia_x = '0; i_wr_ia_y = '0;
    for (int k = 0; k < 256; k++) begin
      m_res_x[k] = '0;
      m_res_y[k] = '0;
    end

    // Reset held three cycles with random inputs
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_data", o_b1_x | o_b1_y | o_b2_x | o_b2_y | o_m_b2 | o_a_b1_x | o_a_b1_y |
            o_rd_ax | o_rd_ay | o_checksum, 32'h0);
      check("rst_ctl", {30'h0, o_busy, o_done}, 32'h0);
      for (int f = 0; f < 7; f++) rv[f] = $urandom;
      set_wr(int'($urandom_range(0, 255)), rv);
      i_wr_en   = 1'($urandom);
      i_start   = 1'($urandom);
      i_count   = 9'($urandom);
      i_rd_addr = 8'($urandom);
    end
    @(negedge clk);
    i_rst = 1'b0; i_wr_en = 1'b0; i_start = 1'b0;

    load_all();

    // Basic 3-record stream
    run(3, 0, 0);
    for (int k = 0; k < 3; k++) rd_chk(k);

    // Zero count
    run(0, 0, 0);
    for (int k = 0; k < 3; k++) rd_chk(k);

    // Count clamped to depth
    run(300, 0, 0);
    rd_chk(0);
    rd_chk(128);
    rd_chk(255);

    // Start and write while busy are ignored; record 0 then re-streamed
    run(10, 5, 0);
    run(1, 0, 0);
    rd_chk(0);

    // Reset in the middle of a run, then a clean run
    run(20, 0, 10);
    run(20, 0, 0);
    rd_chk(0);
    rd_chk(19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
